// File: rtl/if_stage.sv
// ---------------------------------------------------------------------------
// if_stage -- instruction fetch stage with a pre-IF request FSM.
//
// A single outstanding request is made on the inst SRAM-like interface
// (req/addr_ok, then data_ok/rdata). The returned instruction lands in the
// fs register (presented to ID). If fs is occupied and not leaving, it
// lands in a one-entry skid buffer. Fetch pauses while that buffer is full.
// A branch cancel arriving while a request is in flight is remembered in
// br_buf. The in-flight data is then discarded on return.
//
// Ports
//   clk, resetn           clock, synchronous active-low reset
//   ID_allowin            decode can accept an instruction this cycle
//   BR_BUS[33:0]          {br_target, br_taken, br_taken_cancel}
//   IF_to_ID_valid/BUS    {fs_pc, fs_inst} handed to decode
//   inst_sram_*           read-only fetch port (write side tied off)
// ---------------------------------------------------------------------------
module if_stage #(
  parameter logic [31:0] RESET_PC = 32'h1c000000
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic        ID_allowin,
  input  logic [33:0] BR_BUS,
  output logic        IF_to_ID_valid,
  output logic [63:0] IF_to_ID_BUS,
  output logic        inst_sram_req,
  output logic        inst_sram_wr,
  output logic [1:0]  inst_sram_size,
  output logic [3:0]  inst_sram_wstrb,
  output logic [31:0] inst_sram_addr,
  output logic [31:0] inst_sram_wdata,
  input  logic        inst_sram_addr_ok,
  input  logic        inst_sram_data_ok,
  input  logic [31:0] inst_sram_rdata
);

  typedef enum logic [1:0] {PF_IDLE, PF_REQ, PF_WAIT} pf_state_t;

  pf_state_t   r_state;
  logic [31:0] r_req_pc;
  logic        r_fs_valid;
  logic [31:0] r_fs_pc, r_fs_inst;
  logic        r_buf_valid;
  logic [31:0] r_buf_pc, r_buf_inst;
  logic        r_discard;
  logic        r_br_buf_valid;
  logic [31:0] r_br_buf_target;

  logic        w_cancel;
  logic [31:0] w_br_target;
  logic        w_unused_br_taken;
  logic [31:0] w_nextpc;
  logic        w_data_in, w_accept, w_fs_leave, w_to_fs, w_to_buf;
  logic        w_buf_valid_nx;

  assign w_cancel          = BR_BUS[0];
  assign w_unused_br_taken = BR_BUS[1];
  assign w_br_target       = BR_BUS[33:2];

  assign w_nextpc = r_br_buf_valid ? r_br_buf_target :
                    w_cancel       ? w_br_target     : r_req_pc + 32'd4;

  // Data is kept only if no older cancel is pending and none arrives now.
  assign w_data_in  = (r_state == PF_WAIT) & inst_sram_data_ok;
  assign w_accept   = w_data_in & ~r_discard & ~w_cancel;
  assign w_fs_leave = r_fs_valid & ID_allowin;
  assign w_to_fs    = w_accept & (~r_fs_valid | w_fs_leave);
  assign w_to_buf   = w_accept & ~w_to_fs;

  // Skid-buffer occupancy after this cycle. Fetch only restarts when it is empty.
  // Data never arrives while buf is full, because fetch is paused then. So a
  // write and a buf->fs move cannot both happen in one cycle.
  assign w_buf_valid_nx = ~w_cancel & (w_to_buf | (r_buf_valid & ~w_fs_leave));

  assign inst_sram_req   = (r_state == PF_REQ);
  assign inst_sram_addr  = r_req_pc;
  assign inst_sram_wr    = 1'b0;
  assign inst_sram_size  = 2'd2;
  assign inst_sram_wstrb = 4'd0;
  assign inst_sram_wdata = 32'd0;

  assign IF_to_ID_valid = r_fs_valid;
  assign IF_to_ID_BUS   = {r_fs_pc, r_fs_inst};

  always_ff @(posedge clk) begin
    if (!resetn) begin
      r_state         <= PF_IDLE;
      r_req_pc        <= RESET_PC - 32'd4;
      r_fs_valid      <= 1'b0;
      r_fs_pc         <= 32'd0;
      r_fs_inst       <= 32'd0;
      r_buf_valid     <= 1'b0;
      r_buf_pc        <= 32'd0;
      r_buf_inst      <= 32'd0;
      r_discard       <= 1'b0;
      r_br_buf_valid  <= 1'b0;
      r_br_buf_target <= 32'd0;
    end else begin
      // fs / skid buffer
      r_buf_valid <= w_buf_valid_nx;
      if (w_cancel) begin
        r_fs_valid <= 1'b0;
      end else if (w_to_fs) begin
        r_fs_valid <= 1'b1;
        r_fs_pc    <= r_req_pc;
        r_fs_inst  <= inst_sram_rdata;
      end else if (w_fs_leave) begin
        r_fs_valid <= r_buf_valid;
        if (r_buf_valid) begin
          r_fs_pc   <= r_buf_pc;
          r_fs_inst <= r_buf_inst;
        end
      end
      if (w_to_buf) begin
        r_buf_pc   <= r_req_pc;
        r_buf_inst <= inst_sram_rdata;
      end

      // pre-IF request FSM
      case (r_state)
        PF_IDLE: begin
          if (w_cancel) begin
            r_state        <= PF_REQ;
            r_req_pc       <= w_br_target;
            r_br_buf_valid <= 1'b0;
          end else if (!r_buf_valid) begin
            r_state        <= PF_REQ;
            r_req_pc       <= w_nextpc;
            r_br_buf_valid <= 1'b0;
          end
        end
        PF_REQ: begin
          // The request stays up even when cancelled. Its data is dropped later.
          if (w_cancel) begin
            r_discard       <= 1'b1;
            r_br_buf_valid  <= 1'b1;
            r_br_buf_target <= w_br_target;
          end
          if (inst_sram_addr_ok) r_state <= PF_WAIT;
        end
        PF_WAIT: begin
          if (inst_sram_data_ok) begin
            r_discard      <= 1'b0;
            r_br_buf_valid <= 1'b0;
            r_state        <= PF_REQ;
            if (w_cancel)              r_req_pc <= w_br_target;
            else if (r_discard)        r_req_pc <= r_br_buf_target;
            else if (w_buf_valid_nx)   r_state  <= PF_IDLE;
            else                       r_req_pc <= w_nextpc;
          end else if (w_cancel) begin
            r_discard       <= 1'b1;
            r_br_buf_valid  <= 1'b1;
            r_br_buf_target <= w_br_target;
          end
        end
        default: r_state <= PF_IDLE;
      endcase
    end
  end

endmodule

// File: doc/if_stage.md
IF_STAGE -- requirements
Module: if_stage

Interface
REQ-001 The block SHALL have parameter RESET_PC, default 32'h1c000000, meaning the first fetch address after reset.
REQ-002 The block SHALL have port clk, input, 1, clock; all state updates on its rising edge.
REQ-003 The block SHALL have port resetn, input, 1, synchronous, active-low reset.
REQ-004 The block SHALL have port ID_allowin, input, 1, decode stage can accept an instruction this cycle.
REQ-005 The block SHALL have port BR_BUS, input, 34, {br_target[31:0], br_taken, br_taken_cancel}; only br_taken_cancel triggers a redirect.
REQ-006 The block SHALL have port IF_to_ID_valid, output, 1, IF_to_ID_BUS holds a valid instruction.
REQ-007 The block SHALL have port IF_to_ID_BUS, output, 64, {fs_pc[31:0], fs_inst[31:0]}.
REQ-008 The block SHALL have port inst_sram_req, output, 1, fetch request valid.
REQ-009 The block SHALL have port inst_sram_addr, output, 32, fetch address.
REQ-010 The block SHALL tie outputs inst_sram_wr (1b) = 0, inst_sram_size (2b) = 2, inst_sram_wstrb (4b) = 0 and inst_sram_wdata (32b) = 0.
REQ-011 The block SHALL have ports inst_sram_addr_ok (1b), inst_sram_data_ok (1b) and inst_sram_rdata (32b), all inputs: request accepted, read data returned, read data.

Function
REQ-012 The block SHALL keep a pre-IF FSM with states PF_IDLE, PF_REQ and PF_WAIT; inst_sram_req = (state==PF_REQ); inst_sram_addr = req_pc.
REQ-013 The block SHALL compute nextpc = br_buf_valid ? br_buf_target : br_taken_cancel ? br_target : req_pc+4, with 32-bit wrap-around on the +4.
REQ-014 The block SHALL move PF_IDLE->PF_REQ when buf_valid==0 and load req_pc<=nextpc, clearing br_buf_valid if it was used.
REQ-015 The block SHALL hold req high and req_pc stable in PF_REQ until addr_ok, then move PF_REQ->PF_WAIT; at most one request is outstanding.
REQ-016 In PF_WAIT with data_ok and discard==0, the block SHALL write {req_pc, rdata} into fs if fs is empty or leaving (fs_valid & ID_allowin), otherwise into the one-entry skid buffer (buf_valid<=1).
REQ-017 In PF_WAIT with data_ok, the block SHALL go to PF_REQ (req_pc<=nextpc) if buf_valid is 0 after that cycle's write, else to PF_IDLE.
REQ-018 The block SHALL drive IF_to_ID_valid = fs_valid; fs leaves when fs_valid & ID_allowin; on leave, if buf_valid then buf moves to fs and buf_valid<=0, else fs_valid<=0 unless written per REQ-016.
REQ-019 On br_taken_cancel the block SHALL clear fs_valid and buf_valid in that cycle, overriding any fs/buf write or move.
REQ-020 On br_taken_cancel in PF_IDLE, the block SHALL issue the redirect directly: PF_REQ with req_pc<=br_target, with no discard.
REQ-021 On br_taken_cancel in PF_REQ or PF_WAIT, the block SHALL set discard<=1, br_buf_valid<=1 and br_buf_target<=br_target; a later cancel overwrites br_buf_target.
REQ-022 On br_taken_cancel in the same cycle as data_ok in PF_WAIT, the block SHALL drop the returned data and go to PF_REQ with req_pc<=br_target, leaving discard and br_buf unset.
REQ-023 On data_ok with discard==1, the block SHALL drop the data, clear discard, and go to PF_REQ with req_pc<=br_buf_target, clearing br_buf_valid.
REQ-024 The block SHALL ignore data_ok outside PF_WAIT and addr_ok outside PF_REQ.
REQ-025 With addr_ok and data_ok each returning one cycle after request, the block SHALL sustain one instruction per 2 cycles when ID never stalls.

Reset
REQ-026 When resetn is 0 at a clock edge, the block SHALL set state=PF_IDLE, req_pc=RESET_PC-4, fs_valid=0, buf_valid=0, discard=0, br_buf_valid=0, br_buf_target=0, and fs_pc/fs_inst=0.
REQ-027 Reset asserted while a request is outstanding SHALL abandon that request; the block SHALL ignore any data_ok arriving while in PF_IDLE after reset.
REQ-028 The block SHALL assert inst_sram_req first in the cycle after the first edge with resetn=1.

Verification
REQ-029 Reset release, addr_ok and data_ok immediate, ID_allowin=1 -> addresses 1c000000, 1c000004, 1c000008 with IF_to_ID_BUS pc fields matching and no gaps beyond REQ-025.
REQ-030 ID_allowin=0 for 6 cycles -> fs and buf both fill, req stays low; on release, the two instructions are delivered in order and fetch resumes at pc+4 of the last one.
REQ-031 br_taken_cancel with target 1c000100 while in PF_WAIT for 1c000008 -> data for 1c000008 never reaches ID; next request addr=1c000100.
REQ-032 br_taken_cancel (target 1c000200) while req held with addr_ok=0 for 3 cycles -> addr stays 1c00000c until addr_ok; its data is dropped; next addr=1c000200.
REQ-033 br_taken_cancel coincident with data_ok -> data dropped, req in the next cycle addr=br_target, discard=0.
REQ-034 resetn pulled low mid-PF_WAIT, then data_ok pulsed -> IF_to_ID_valid stays 0 and the first request after release addr=1c000000.
